// File: rtl/px_stream_router.sv
// ---------------------------------------------------------------------------
// px_stream_router
//
// Routes pixel traffic between the SPI front end, the LFSR block and the
// gray/sobel core according to a run-time mode. Results headed back to SPI
// are queued in a small FIFO so SPI readout can stall without losing pixels.
// A mode change first drains the datapath (no forwarding, results still
// collected and delivered) and only then switches, so nothing from the old
// mode leaks into the new one.
//
// Ports
//   clk_i, nreset_i            clock, asynchronous active-low reset
//   mode_i                     requested mode (0 BYPASS, 1 LFSR_PX,
//                              2 LFSR_CFG, 3 LOOPBACK)
//   spi_px_i / spi_px_rdy_i    pixel strobe from SPI
//   spi_tx_ready_i             SPI can take an output pixel
//   spi_px_o / spi_px_rdy_o    pixel strobe to SPI (FIFO head)
//   core_px_o / core_px_rdy_o  pixel strobe to the core
//   core_px_i / core_px_rdy_i  result strobe from the core
//   lfsr_px_i / lfsr_px_rdy_i  pixel strobe from the LFSR
//   lfsr_cfg_o / lfsr_cfg_rdy_o config word strobe to the LFSR
//   lfsr_cfg_i / lfsr_cfg_rdy_i config readback strobe from the LFSR
//   mode_active_o              mode currently in effect
//   busy_o                     draining or switching
//   fifo_level_o               result FIFO occupancy
//   overflow_o                 sticky: a result was dropped (cleared on switch)
//   px_count_o                 SPI output pulses since the last switch
// ---------------------------------------------------------------------------
module px_stream_router #(
    parameter int PIXEL_BITS   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 16,
    parameter int COUNT_BITS   = 16
) (
    input  logic                        clk_i,
    input  logic                        nreset_i,
    input  logic [1:0]                  mode_i,
    input  logic [PIXEL_BITS-1:0]       spi_px_i,
    input  logic                        spi_px_rdy_i,
    input  logic                        spi_tx_ready_i,
    output logic [PIXEL_BITS-1:0]       spi_px_o,
    output logic                        spi_px_rdy_o,
    output logic [PIXEL_BITS-1:0]       core_px_o,
    output logic                        core_px_rdy_o,
    input  logic [PIXEL_BITS-1:0]       core_px_i,
    input  logic                        core_px_rdy_i,
    input  logic [PIXEL_BITS-1:0]       lfsr_px_i,
    input  logic                        lfsr_px_rdy_i,
    output logic [PIXEL_BITS-1:0]       lfsr_cfg_o,
    output logic                        lfsr_cfg_rdy_o,
    input  logic [PIXEL_BITS-1:0]       lfsr_cfg_i,
    input  logic                        lfsr_cfg_rdy_i,
    output logic [1:0]                  mode_active_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o,
    output logic [COUNT_BITS-1:0]       px_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int QW    = $clog2(DRAIN_CYCLES + 1);

    localparam logic [QW-1:0]    QUIET_DONE = QW'(DRAIN_CYCLES);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] MODE_BYPASS   = 2'd0;
    localparam logic [1:0] MODE_LFSR_PX  = 2'd1;
    localparam logic [1:0] MODE_LFSR_CFG = 2'd2;
    localparam logic [1:0] MODE_LOOPBACK = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    // Quiet counter saturates once the required window has been seen.
    function automatic logic [QW-1:0] quiet_inc(input logic [QW-1:0] q);
        return (q == QUIET_DONE) ? q : q + QW'(1);
    endfunction

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [QW-1:0]           quiet_q, quiet_d;

    logic [PIXEL_BITS-1:0]   core_px_q, core_px_d;
    logic                    core_rdy_q, core_rdy_d;
    logic [PIXEL_BITS-1:0]   cfg_px_q, cfg_px_d;
    logic                    cfg_rdy_q, cfg_rdy_d;

    logic [PIXEL_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;

    logic [PIXEL_BITS-1:0]   spi_px_q, spi_px_d;
    logic                    spi_rdy_q, spi_rdy_d;
    logic                    ovf_q, ovf_d;
    logic [COUNT_BITS-1:0]   cnt_q, cnt_d;

    logic                    mode_match;
    logic                    fwd_en;
    logic                    push_req;
    logic [PIXEL_BITS-1:0]   push_px;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    assign mode_match = (mode_i == mode_q);
    assign fwd_en     = (state_q == ST_RUN) && mode_match;
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);

    // Output pacing: spi_rdy_q blocks back-to-back pops, giving one idle
    // cycle between output strobes. A fresh push is not visible to pop until
    // the next cycle, so the FIFO never falls through.
    assign pop     = !fifo_empty && spi_tx_ready_i && !spi_rdy_q;
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    // Forward path: source strobe registered towards its sink.
    always_comb begin
        core_rdy_d = 1'b0;
        core_px_d  = core_px_q;
        cfg_rdy_d  = 1'b0;
        cfg_px_d   = cfg_px_q;
        if (fwd_en) begin
            case (mode_q)
                MODE_BYPASS: begin
                    if (spi_px_rdy_i) begin
                        core_rdy_d = 1'b1;
                        core_px_d  = spi_px_i;
                    end
                end
                MODE_LFSR_PX: begin
                    if (lfsr_px_rdy_i) begin
                        core_rdy_d = 1'b1;
                        core_px_d  = lfsr_px_i;
                    end
                end
                MODE_LFSR_CFG: begin
                    if (spi_px_rdy_i) begin
                        cfg_rdy_d = 1'b1;
                        cfg_px_d  = spi_px_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result source selection. Loopback pushes SPI input directly, but only
    // while actually forwarding. Nothing is accepted in the SWITCH cycle so
    // a late result of the old mode cannot enter the new one.
    always_comb begin
        push_req = 1'b0;
        push_px  = core_px_i;
        case (mode_q)
            MODE_BYPASS, MODE_LFSR_PX: begin
                push_req = core_px_rdy_i;
                push_px  = core_px_i;
            end
            MODE_LFSR_CFG: begin
                push_req = lfsr_cfg_rdy_i;
                push_px  = lfsr_cfg_i;
            end
            default: begin
                push_req = fwd_en && spi_px_rdy_i;
                push_px  = spi_px_i;
            end
        endcase
        if (state_q == ST_SWITCH) begin
            push_req = 1'b0;
        end
    end

    // FIFO bookkeeping and SPI output.
    always_comb begin
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d   = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        spi_rdy_d = pop;
        spi_px_d  = pop ? mem_q[rd_ptr_q] : spi_px_q;
        cnt_d     = pop ? cnt_q + COUNT_BITS'(1) : cnt_q;
        ovf_d     = ovf_q | drop;
        if (state_q == ST_SWITCH) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Mode FSM. The quiet window only counts cycles in which the FIFO is
    // already empty and no result arrived, so the switch happens a fixed
    // DRAIN_CYCLES after the last result has left.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        quiet_d = '0;
        case (state_q)
            ST_RUN: begin
                if (!mode_match) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                quiet_d = (push_ok || !fifo_empty) ? '0 : quiet_inc(quiet_q);
                if (mode_match) begin
                    state_d = ST_RUN;
                end else if (quiet_d == QUIET_DONE) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                mode_d  = mode_i;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= ST_RUN;
            mode_q     <= '0;
            quiet_q    <= '0;
            core_px_q  <= '0;
            core_rdy_q <= 1'b0;
            cfg_px_q   <= '0;
            cfg_rdy_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            spi_px_q   <= '0;
            spi_rdy_q  <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            quiet_q    <= quiet_d;
            core_px_q  <= core_px_d;
            core_rdy_q <= core_rdy_d;
            cfg_px_q   <= cfg_px_d;
            cfg_rdy_q  <= cfg_rdy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            spi_px_q   <= spi_px_d;
            spi_rdy_q  <= spi_rdy_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_px;
        end
    end

    assign spi_px_o       = spi_px_q;
    assign spi_px_rdy_o   = spi_rdy_q;
    assign core_px_o      = core_px_q;
    assign core_px_rdy_o  = core_rdy_q;
    assign lfsr_cfg_o     = cfg_px_q;
    assign lfsr_cfg_rdy_o = cfg_rdy_q;
    assign mode_active_o  = mode_q;
    assign busy_o         = (state_q != ST_RUN);
    assign fifo_level_o   = level_q;
    assign overflow_o     = ovf_q;
    assign px_count_o     = cnt_q;

endmodule

// File: tb/tb_px_stream_router.sv
module tb_px_stream_router;

    localparam int PB = 8;
    localparam int FD = 4;
    localparam int DC = 16;
    localparam int CB = 16;

    logic          clk_i = 1'b0;
    logic          nreset_i;
    logic [1:0]    mode_i;
    logic [PB-1:0] spi_px_i;
    logic          spi_px_rdy_i;
    logic          spi_tx_ready_i;
    logic [PB-1:0] spi_px_o;
    logic          spi_px_rdy_o;
    logic [PB-1:0] core_px_o;
    logic          core_px_rdy_o;
    logic [PB-1:0] core_px_i;
    logic          core_px_rdy_i;
    logic [PB-1:0] lfsr_px_i;
    logic          lfsr_px_rdy_i;
    logic [PB-1:0] lfsr_cfg_o;
    logic          lfsr_cfg_rdy_o;
    logic [PB-1:0] lfsr_cfg_i;
    logic          lfsr_cfg_rdy_i;
    logic [1:0]    mode_active_o;
    logic          busy_o;
    logic [$clog2(FD):0] fifo_level_o;
    logic          overflow_o;
    logic [CB-1:0] px_count_o;

    always #5 clk_i = ~clk_i;

    px_stream_router #(
        .PIXEL_BITS  (PB),
        .FIFO_DEPTH  (FD),
        .DRAIN_CYCLES(DC),
        .COUNT_BITS  (CB)
    ) dut (
        .clk_i         (clk_i),
        .nreset_i      (nreset_i),
        .mode_i        (mode_i),
        .spi_px_i      (spi_px_i),
        .spi_px_rdy_i  (spi_px_rdy_i),
        .spi_tx_ready_i(spi_tx_ready_i),
        .spi_px_o      (spi_px_o),
        .spi_px_rdy_o  (spi_px_rdy_o),
        .core_px_o     (core_px_o),
        .core_px_rdy_o (core_px_rdy_o),
        .core_px_i     (core_px_i),
        .core_px_rdy_i (core_px_rdy_i),
        .lfsr_px_i     (lfsr_px_i),
        .lfsr_px_rdy_i (lfsr_px_rdy_i),
        .lfsr_cfg_o    (lfsr_cfg_o),
        .lfsr_cfg_rdy_o(lfsr_cfg_rdy_o),
        .lfsr_cfg_i    (lfsr_cfg_i),
        .lfsr_cfg_rdy_i(lfsr_cfg_rdy_i),
        .mode_active_o (mode_active_o),
        .busy_o        (busy_o),
        .fifo_level_o  (fifo_level_o),
        .overflow_o    (overflow_o),
        .px_count_o    (px_count_o)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int spi_pulses = 0;
    int core_pulses = 0;
    logic [PB-1:0] exp_spi[$];
    logic [PB-1:0] e;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (spi_px_rdy_o === 1'b1) spi_pulses++;
        if (core_px_rdy_o === 1'b1) core_pulses++;
    endtask

    task automatic test_reset();
        nreset_i = 1'b0; mode_i = 2'd0; spi_tx_ready_i = 1'b1;
        spi_px_i = '0; spi_px_rdy_i = 1'b0; core_px_i = '0; core_px_rdy_i = 1'b0;
        lfsr_px_i = '0; lfsr_px_rdy_i = 1'b0; lfsr_cfg_i = '0; lfsr_cfg_rdy_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({spi_px_o, spi_px_rdy_o, core_px_o, core_px_rdy_o} !== '0) begin
            n_fail++; $display("FAIL reset_fwd_out: got %h/%b %h/%b, required 0", spi_px_o, spi_px_rdy_o, core_px_o, core_px_rdy_o);
        end
        n_checks++;
        if ({lfsr_cfg_o, lfsr_cfg_rdy_o} !== '0) begin
            n_fail++; $display("FAIL reset_cfg_out: got %h/%b, required 0", lfsr_cfg_o, lfsr_cfg_rdy_o);
        end
        n_checks++;
        if ({mode_active_o, busy_o, fifo_level_o, overflow_o, px_count_o} !== '0) begin
            n_fail++; $display("FAIL reset_status: mode %0d busy %b level %0d ovf %b cnt %0d, required all 0",
                               mode_active_o, busy_o, fifo_level_o, overflow_o, px_count_o);
        end
        nreset_i = 1'b1;
        tick();
    endtask

    task automatic test_mode0_roundtrip();
        spi_px_i = 8'hA5; spi_px_rdy_i = 1'b1;
        tick();
        spi_px_rdy_i = 1'b0;
        n_checks++;
        if (core_px_rdy_o !== 1'b1 || core_px_o !== 8'hA5) begin
            n_fail++; $display("FAIL m0_forward: got rdy %b data %h, required rdy 1 data a5", core_px_rdy_o, core_px_o);
        end
        tick();
        n_checks++;
        if (core_px_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL m0_fwd_strobe_len: got rdy %b, required 0", core_px_rdy_o);
        end
        core_px_i = 8'h3C; core_px_rdy_i = 1'b1; exp_spi.push_back(8'h3C);
        tick();
        core_px_rdy_i = 1'b0;
        n_checks++;
        if (spi_px_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL m0_result_early: got spi rdy %b at j+1, required 0", spi_px_rdy_o);
        end
        tick();
        n_checks++;
        if (spi_px_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL m0_result_latency: got spi rdy %b at j+2, required 1", spi_px_rdy_o);
        end else begin
            e = exp_spi.pop_front();
            if (spi_px_o !== e) begin
                n_fail++; $display("FAIL m0_result_data: got %h, required %h", spi_px_o, e);
            end
        end
        n_checks++;
        if (px_count_o !== 16'd1) begin
            n_fail++; $display("FAIL m0_px_count: got %0d, required 1", px_count_o);
        end
        tick(); tick();
        n_checks++;
        if (spi_px_rdy_o !== 1'b0 || spi_px_o !== 8'h3C) begin
            n_fail++; $display("FAIL m0_hold: got rdy %b data %h, required rdy 0 data 3c", spi_px_rdy_o, spi_px_o);
        end
    endtask

    task automatic test_overflow();
        int base;
        int last;
        spi_tx_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            core_px_i = PB'(i); core_px_rdy_i = 1'b1;
            if (i <= 4) exp_spi.push_back(PB'(i));
            tick();
        end
        core_px_rdy_i = 1'b0;
        tick();
        n_checks++;
        if (fifo_level_o !== 3'd4 || overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_fill: got level %0d ovf %b, required level 4 ovf 1", fifo_level_o, overflow_o);
        end
        base = spi_pulses;
        last = -1;
        spi_tx_ready_i = 1'b1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (spi_px_rdy_o === 1'b1) begin
                n_checks++;
                if (exp_spi.size() == 0) begin
                    n_fail++; $display("FAIL ovf_unexpected: got %h, required no output", spi_px_o);
                end else begin
                    e = exp_spi.pop_front();
                    if (spi_px_o !== e) begin
                        n_fail++; $display("FAIL ovf_order: got %h, required %h", spi_px_o, e);
                    end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 2) begin
                        n_fail++; $display("FAIL ovf_spacing: got %0d cycles, required 2", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_checks++;
        if (spi_pulses - base != 4 || exp_spi.size() != 0) begin
            n_fail++; $display("FAIL ovf_count: got %0d pulses, %0d pending, required 4 and 0", spi_pulses - base, exp_spi.size());
        end
        n_checks++;
        if (overflow_o !== 1'b1 || fifo_level_o !== 3'd0 || px_count_o !== 16'd5) begin
            n_fail++; $display("FAIL ovf_after: got ovf %b level %0d cnt %0d, required 1 0 5", overflow_o, fifo_level_o, px_count_o);
        end
    endtask

    task automatic test_mode_switch();
        int base_core;
        int base_spi;
        int empty_cyc;
        int sw_cyc;
        int busy_bad;
        spi_tx_ready_i = 1'b0;
        core_px_i = 8'h11; core_px_rdy_i = 1'b1; exp_spi.push_back(8'h11);
        tick();
        core_px_i = 8'h22; exp_spi.push_back(8'h22);
        tick();
        core_px_rdy_i = 1'b0;
        base_core = core_pulses; base_spi = spi_pulses;
        empty_cyc = -1; sw_cyc = -1; busy_bad = 0;
        mode_i = 2'd3; spi_tx_ready_i = 1'b1; spi_px_i = 8'hEE; spi_px_rdy_i = 1'b1;
        for (int t = 0; t < 60 && sw_cyc < 0; t++) begin
            tick();
            if (t == 3) spi_px_rdy_i = 1'b0;
            if (spi_px_rdy_o === 1'b1) begin
                n_checks++;
                if (exp_spi.size() == 0) begin
                    n_fail++; $display("FAIL sw_unexpected: got %h, required no output", spi_px_o);
                end else begin
                    e = exp_spi.pop_front();
                    if (spi_px_o !== e) begin
                        n_fail++; $display("FAIL sw_drain_data: got %h, required %h", spi_px_o, e);
                    end
                end
            end
            if (empty_cyc < 0 && fifo_level_o === 3'd0) empty_cyc = cyc;
            if (mode_active_o === 2'd3) sw_cyc = cyc;
            else if (busy_o !== 1'b1) busy_bad++;
        end
        n_checks++;
        if (sw_cyc < 0 || empty_cyc < 0) begin
            n_fail++; $display("FAIL sw_timeout: got mode %0d level %0d, required mode 3 within 60 cycles", mode_active_o, fifo_level_o);
        end else if (sw_cyc - empty_cyc != DC + 1) begin
            n_fail++; $display("FAIL sw_timing: got %0d cycles after empty, required %0d", sw_cyc - empty_cyc, DC + 1);
        end
        n_checks++;
        if (busy_bad != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL sw_busy: got %0d idle drain cycles, busy now %b, required 0 and 0", busy_bad, busy_o);
        end
        n_checks++;
        if (core_pulses != base_core || spi_pulses - base_spi != 2 || exp_spi.size() != 0) begin
            n_fail++; $display("FAIL sw_traffic: got core %0d spi %0d pending %0d, required 0 2 0",
                               core_pulses - base_core, spi_pulses - base_spi, exp_spi.size());
        end
        n_checks++;
        if (px_count_o !== 16'd0 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL sw_clear: got cnt %0d ovf %b, required 0 0", px_count_o, overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        spi_tx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spi_px_i = 8'h81 + PB'(i); spi_px_rdy_i = 1'b1; exp_spi.push_back(spi_px_i);
            tick();
        end
        spi_px_rdy_i = 1'b0;
        tick();
        n_checks++;
        if (fifo_level_o !== 3'd4 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL full_fill: got level %0d ovf %b, required 4 0", fifo_level_o, overflow_o);
        end
        spi_px_i = 8'h85; spi_px_rdy_i = 1'b1; spi_tx_ready_i = 1'b1; exp_spi.push_back(8'h85);
        tick();
        spi_px_rdy_i = 1'b0; spi_tx_ready_i = 1'b0;
        n_checks++;
        if (fifo_level_o !== 3'd4 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop: got level %0d ovf %b, required 4 0", fifo_level_o, overflow_o);
        end
        spi_tx_ready_i = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (spi_px_rdy_o === 1'b1) begin
                n_checks++;
                if (exp_spi.size() == 0) begin
                    n_fail++; $display("FAIL full_unexpected: got %h, required no output", spi_px_o);
                end else begin
                    e = exp_spi.pop_front();
                    if (spi_px_o !== e) begin
                        n_fail++; $display("FAIL full_order: got %h, required %h", spi_px_o, e);
                    end
                end
            end
            tick();
        end
        n_checks++;
        if (exp_spi.size() != 0 || fifo_level_o !== 3'd0 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL full_end: got pending %0d level %0d ovf %b, required 0 0 0", exp_spi.size(), fifo_level_o, overflow_o);
        end
    endtask

    task automatic wait_mode(input logic [1:0] m);
        int n;
        n = 0;
        while (mode_active_o !== m && n < 60) begin
            tick();
            n++;
        end
        n_checks++;
        if (mode_active_o !== m) begin
            n_fail++; $display("FAIL wait_mode: got mode %0d, required %0d within 60 cycles", mode_active_o, m);
        end
    endtask

    task automatic test_abort_and_lfsr();
        int stay_bad;
        mode_i = 2'd0;
        wait_mode(2'd0);
        tick();
        mode_i = 2'd2;
        tick(); tick(); tick();
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL abort_busy: got %b, required 1", busy_o);
        end
        mode_i = 2'd0;
        stay_bad = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (mode_active_o !== 2'd0) stay_bad++;
        end
        n_checks++;
        if (stay_bad != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_stay: got %0d cycles off mode 0, busy %b, required 0 0", stay_bad, busy_o);
        end
        mode_i = 2'd2;
        wait_mode(2'd2);
        spi_px_i = 8'h5A; spi_px_rdy_i = 1'b1;
        tick();
        spi_px_rdy_i = 1'b0;
        n_checks++;
        if (lfsr_cfg_rdy_o !== 1'b1 || lfsr_cfg_o !== 8'h5A || core_px_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL m2_cfg: got cfg %b/%h core rdy %b, required 1/5a 0", lfsr_cfg_rdy_o, lfsr_cfg_o, core_px_rdy_o);
        end
        core_px_i = 8'h99; core_px_rdy_i = 1'b1;
        tick();
        core_px_rdy_i = 1'b0;
        n_checks++;
        if (fifo_level_o !== 3'd0) begin
            n_fail++; $display("FAIL m2_ignore_core: got level %0d, required 0", fifo_level_o);
        end
        lfsr_cfg_i = 8'h5A; lfsr_cfg_rdy_i = 1'b1; exp_spi.push_back(8'h5A);
        tick();
        lfsr_cfg_rdy_i = 1'b0;
        tick();
        n_checks++;
        if (spi_px_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL m2_readback: got spi rdy %b at j+2, required 1", spi_px_rdy_o);
        end else begin
            e = exp_spi.pop_front();
            if (spi_px_o !== e) begin
                n_fail++; $display("FAIL m2_readback_data: got %h, required %h", spi_px_o, e);
            end
        end
        mode_i = 2'd1;
        wait_mode(2'd1);
        lfsr_px_i = 8'h77; lfsr_px_rdy_i = 1'b1; spi_px_i = 8'h12; spi_px_rdy_i = 1'b1;
        tick();
        lfsr_px_rdy_i = 1'b0; spi_px_rdy_i = 1'b0;
        n_checks++;
        if (core_px_rdy_o !== 1'b1 || core_px_o !== 8'h77 || lfsr_cfg_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL m1_lfsr: got core %b/%h cfg rdy %b, required 1/77 0", core_px_rdy_o, core_px_o, lfsr_cfg_rdy_o);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        spi_tx_ready_i = 1'b0;
        core_px_i = 8'h31; core_px_rdy_i = 1'b1;
        tick();
        core_px_i = 8'h32;
        tick();
        core_px_rdy_i = 1'b0;
        n_checks++;
        if (fifo_level_o !== 3'd2) begin
            n_fail++; $display("FAIL rst_prefill: got level %0d, required 2", fifo_level_o);
        end
        @(posedge clk_i);
        #3;
        nreset_i = 1'b0;
        #1;
        n_checks++;
        if (fifo_level_o !== 3'd0 || mode_active_o !== 2'd0 || core_px_o !== 8'h00 || busy_o !== 1'b0 || px_count_o !== 16'd0) begin
            n_fail++; $display("FAIL rst_async: got level %0d mode %0d core %h busy %b cnt %0d, required all 0",
                               fifo_level_o, mode_active_o, core_px_o, busy_o, px_count_o);
        end
        mode_i = 2'd0; spi_tx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        nreset_i = 1'b1;
        spi_px_i = 8'h42; spi_px_rdy_i = 1'b1;
        tick();
        spi_px_rdy_i = 1'b0;
        n_checks++;
        if (core_px_rdy_o !== 1'b1 || core_px_o !== 8'h42) begin
            n_fail++; $display("FAIL rst_resume: got rdy %b data %h, required 1 42", core_px_rdy_o, core_px_o);
        end
        base = spi_pulses;
        repeat (5) tick();
        n_checks++;
        if (spi_pulses != base || fifo_level_o !== 3'd0) begin
            n_fail++; $display("FAIL rst_discard: got %0d pulses level %0d, required 0 0", spi_pulses - base, fifo_level_o);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_roundtrip();
        test_overflow();
        test_mode_switch();
        test_full_push_pop();
        test_abort_and_lfsr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
